// File: rtl/mem_access_unit.sv
// Memory-stage responder: 64-bit ld/sd carried out as two 32-bit bus beats (low word first),
// with misalignment/illegal-op detection, a per-beat ack timeout and a pipeline stall.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [63:0]       alu_result,
    input  logic [63:0]       write_data,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [63:0]       read_data,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [63:0]         r_wdata;
    logic                r_we;
    logic                r_err;
    logic [31:0]         r_lo;
    logic [63:0]         r_read_data;
    logic [TW-1:0]       r_tcnt;
    logic                w_accept;
    logic                w_bad;
    logic                w_tmo_hit;

    assign w_accept  = req_valid && (r_state == S_IDLE) && (MemRead || MemWrite);
    assign w_bad     = (alu_result[2:0] != 3'b000) || (MemRead && MemWrite);
    assign w_tmo_hit = (TIMEOUT != 0) && !bus_ack && (r_tcnt == TMO_LAST);

    // Upper effective-address bits beyond the bus width are intentionally dropped.
    generate
        if (ADDR_W < 64) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^alu_result[63:ADDR_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_bad ? S_RESP : S_LO;
                end
            end
            S_LO: begin
                bus_req   = 1'b1;
                bus_we    = r_we;
                bus_addr  = r_addr;
                bus_wdata = r_wdata[31:0];
                if (bus_ack) begin
                    w_next = S_HI;
                end else if (w_tmo_hit) begin
                    w_next = S_RESP;
                end
            end
            S_HI: begin
                bus_req   = 1'b1;
                bus_we    = r_we;
                bus_addr  = r_addr + ADDR_W'(4);
                bus_wdata = r_wdata[63:32];
                if (bus_ack || w_tmo_hit) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        stall = (r_state == S_LO) || (r_state == S_HI) || w_accept ||
                ((r_state == S_IDLE) && (w_next == S_RESP));
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_err   = (r_state == S_RESP) && r_err;
    assign read_data  = r_read_data;

    // Error flag is decided at accept (bad request) or when a beat times out;
    // read_data is written only by a completed high read beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_lo        <= '0;
            r_read_data <= '0;
            r_tcnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= alu_result[ADDR_W-1:0];
                        r_wdata <= write_data;
                        r_we    <= MemWrite;
                        r_err   <= w_bad;
                        r_tcnt  <= '0;
                    end
                end
                S_LO: begin
                    if (bus_ack) begin
                        if (!r_we) begin
                            r_lo <= bus_rdata;
                        end
                        r_tcnt <= '0;
                    end else if (w_tmo_hit) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_HI: begin
                    if (bus_ack) begin
                        if (!r_we) begin
                            r_read_data <= {bus_rdata, r_lo};
                        end
                        r_err <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a configurable-latency bus responder.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] alu_result;
    logic [63:0] write_data;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] read_data;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    // bus responder controls
    logic        ack_en;
    int          ack_delay;
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    int          wcnt;

    // monitor state
    int          resp_cnt;
    int          breq_cycles;
    int          unstable;
    logic        pend;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_we;
    logic [31:0] beat_addr_q[$];
    logic [31:0] beat_wdata_q[$];
    logic        beat_we_q[$];

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .alu_result (alu_result),
        .write_data (write_data),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .read_data  (read_data),
        .stall      (stall),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_ack   = bus_req && ack_en && (wcnt >= ack_delay);
    assign bus_rdata = bus_addr[2] ? hi_word : lo_word;

    initial begin
        wcnt = 0; resp_cnt = 0; breq_cycles = 0; unstable = 0;
        pend = 1'b0; p_addr = '0; p_wdata = '0; p_we = 1'b0;
    end

    always @(posedge clk) begin
        if (pend && bus_req && (bus_addr != p_addr || bus_wdata != p_wdata || bus_we != p_we))
            unstable <= unstable + 1;
        pend    <= bus_req && !bus_ack;
        p_addr  <= bus_addr;
        p_wdata <= bus_wdata;
        p_we    <= bus_we;
        if (bus_req) breq_cycles <= breq_cycles + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (bus_req && bus_ack) begin
            beat_addr_q.push_back(bus_addr);
            beat_wdata_q.push_back(bus_wdata);
            beat_we_q.push_back(bus_we);
        end
        if (!bus_req || bus_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] d);
        req_valid  = 1'b1;
        MemRead    = rd;
        MemWrite   = wr;
        alu_result = a;
        write_data = d;
        #1;
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drop_req();
        alu_result = '0; write_data = '0;
        ack_en = 1'b1; ack_delay = 0; lo_word = '0; hi_word = '0;
        repeat (2) tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        checks++; if (read_data !== 64'h0) begin errors++; $display("FAIL reset_read_data: got %h want 0", read_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_aligned_load();
        int b0;
        b0 = beat_addr_q.size();
        ack_en = 1'b1; ack_delay = 0; lo_word = 32'hDEADBEEF; hi_word = 32'h01234567;
        drive_req(1'b1, 1'b0, 64'h1000, 64'h0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall_T: got %b want 1", stall); end
        tick(); drop_req(); #1;
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h1000) begin errors++; $display("FAIL load_lo_beat: got req=%b addr=%h want 1/00001000", bus_req, bus_addr); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall_T1: got %b want 1", stall); end
        tick();
        checks++; if (bus_addr !== 32'h1004 || bus_we !== 1'b0) begin errors++; $display("FAIL load_hi_beat: got addr=%h we=%b want 00001004/0", bus_addr, bus_we); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall_T2: got %b want 1", stall); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL load_resp_T3: got valid=%b err=%b want 1/0", resp_valid, resp_err); end
        checks++; if (read_data !== 64'h01234567DEADBEEF) begin errors++; $display("FAIL load_read_data: got %h want 01234567deadbeef", read_data); end
        checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL load_resp_idle_bus: got stall=%b req=%b want 0/0", stall, bus_req); end
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL load_back_idle: got valid=%b ready=%b want 0/1", resp_valid, req_ready); end
        checks++; if (beat_addr_q.size() != b0 + 2) begin errors++; $display("FAIL load_beat_count: got %0d want %0d", beat_addr_q.size() - b0, 2); end
    endtask

    task automatic test_store_delayed();
        int b0, r0, q0, n;
        b0 = beat_addr_q.size(); r0 = resp_cnt; q0 = breq_cycles;
        ack_en = 1'b1; ack_delay = 3;
        drive_req(1'b0, 1'b1, 64'h2008, 64'hAAAABBBBCCCCDDDD);
        tick(); drop_req();
        n = 1;
        while (resp_valid !== 1'b1 && n < 30) begin tick(); n++; end
        checks++; if (n != 9) begin errors++; $display("FAIL store_latency: got %0d want 9", n); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL store_resp_err: got %b want 0", resp_err); end
        checks++; if (read_data !== 64'h01234567DEADBEEF) begin errors++; $display("FAIL store_read_data_kept: got %h want 01234567deadbeef", read_data); end
        tick();
        checks++; if (resp_cnt - r0 != 1) begin errors++; $display("FAIL store_resp_once: got %0d want 1", resp_cnt - r0); end
        checks++; if (breq_cycles - q0 != 8) begin errors++; $display("FAIL store_req_cycles: got %0d want 8", breq_cycles - q0); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL store_stable: got %0d changes want 0", unstable); end
        if (beat_addr_q.size() >= b0 + 2) begin
            checks++; if (beat_addr_q[b0] !== 32'h2008 || beat_wdata_q[b0] !== 32'hCCCCDDDD || beat_we_q[b0] !== 1'b1) begin
                errors++; $display("FAIL store_beat0: got addr=%h data=%h we=%b want 00002008/ccccdddd/1", beat_addr_q[b0], beat_wdata_q[b0], beat_we_q[b0]); end
            checks++; if (beat_addr_q[b0+1] !== 32'h200C || beat_wdata_q[b0+1] !== 32'hAAAABBBB || beat_we_q[b0+1] !== 1'b1) begin
                errors++; $display("FAIL store_beat1: got addr=%h data=%h we=%b want 0000200c/aaaabbbb/1", beat_addr_q[b0+1], beat_wdata_q[b0+1], beat_we_q[b0+1]); end
        end else begin
            checks++; errors++; $display("FAIL store_beats: got %0d beats want 2", beat_addr_q.size() - b0);
        end
    endtask

    task automatic test_misaligned();
        int q0;
        q0 = breq_cycles;
        ack_en = 1'b1; ack_delay = 0;
        drive_req(1'b1, 1'b0, 64'h1004, 64'h0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL misal_stall_T: got %b want 1", stall); end
        tick(); drop_req(); #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL misal_resp: got valid=%b err=%b want 1/1", resp_valid, resp_err); end
        checks++; if (req_ready !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL misal_resp_ctrl: got ready=%b stall=%b want 0/0", req_ready, stall); end
        tick();
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL misal_idle: got ready=%b valid=%b want 1/0", req_ready, resp_valid); end
        checks++; if (breq_cycles != q0) begin errors++; $display("FAIL misal_no_bus: got %0d cycles want 0", breq_cycles - q0); end
        checks++; if (read_data !== 64'h01234567DEADBEEF) begin errors++; $display("FAIL misal_read_data: got %h want 01234567deadbeef", read_data); end
    endtask

    task automatic test_timeout();
        int q0, n;
        q0 = breq_cycles;
        ack_en = 1'b0; lo_word = 32'h55555555; hi_word = 32'h66666666;
        drive_req(1'b1, 1'b0, 64'h3000, 64'h0);
        tick(); drop_req();
        n = 1;
        while (resp_valid !== 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (n != 17) begin errors++; $display("FAIL tmo_latency: got %0d want 17", n); end
        checks++; if (resp_err !== 1'b1 || bus_req !== 1'b0) begin errors++; $display("FAIL tmo_resp: got err=%b req=%b want 1/0", resp_err, bus_req); end
        checks++; if (breq_cycles - q0 != 16) begin errors++; $display("FAIL tmo_req_cycles: got %0d want 16", breq_cycles - q0); end
        checks++; if (read_data !== 64'h01234567DEADBEEF) begin errors++; $display("FAIL tmo_read_data: got %h want 01234567deadbeef", read_data); end
        tick();
        ack_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int r0, n;
        r0 = resp_cnt;
        ack_en = 1'b1; ack_delay = 2; lo_word = 32'h77777777; hi_word = 32'h88888888;
        drive_req(1'b1, 1'b0, 64'h4000, 64'h0);
        tick(); drop_req();
        repeat (4) tick();
        checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h4004) begin errors++; $display("FAIL rst_in_hi: got req=%b addr=%h want 1/00004004", bus_req, bus_addr); end
        rst_n = 1'b0; #1;
        checks++; if (bus_req !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) begin
            errors++; $display("FAIL rst_mid_abort: got req=%b ready=%b stall=%b want 0/1/0", bus_req, req_ready, stall); end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        checks++; if (resp_cnt != r0) begin errors++; $display("FAIL rst_mid_no_resp: got %0d want 0", resp_cnt - r0); end
        ack_delay = 0; lo_word = 32'h11111111; hi_word = 32'h22222222;
        drive_req(1'b1, 1'b0, 64'h5000, 64'h0);
        tick(); drop_req();
        n = 1;
        while (resp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (n != 3 || resp_err !== 1'b0) begin errors++; $display("FAIL rst_after_load: got lat=%0d err=%b want 3/0", n, resp_err); end
        checks++; if (read_data !== 64'h2222222211111111) begin errors++; $display("FAIL rst_after_data: got %h want 2222222211111111", read_data); end
        tick();
    endtask

    task automatic test_illegal();
        int q0, r0;
        q0 = breq_cycles;
        drive_req(1'b1, 1'b1, 64'h6000, 64'h0);
        tick(); drop_req(); #1;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL illegal_resp: got valid=%b err=%b want 1/1", resp_valid, resp_err); end
        tick();
        checks++; if (breq_cycles != q0) begin errors++; $display("FAIL illegal_no_bus: got %0d cycles want 0", breq_cycles - q0); end
        r0 = resp_cnt;
        drive_req(1'b0, 1'b0, 64'h7000, 64'h0);
        checks++; if (stall !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL nop_stall: got stall=%b ready=%b want 0/1", stall, req_ready); end
        repeat (3) tick();
        drop_req();
        tick();
        checks++; if (resp_cnt != r0 || breq_cycles != q0) begin
            errors++; $display("FAIL nop_ignored: got resp=%0d bus=%0d want 0/0", resp_cnt - r0, breq_cycles - q0); end
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_store_delayed();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage responder that consumes the execute stage's outputs: the ALU result as the effective address and rs2 data as store data.
- Performs 64-bit ld/sd over a 32-bit request/acknowledge data bus as two beats, low word first.
- Returns load data and a completion/error response.
- Asserts stall so the PC/fetch logic holds while an access is in flight.

Parameters:
- ADDR_W, 32, bus address width; bus_addr is alu_result[ADDR_W-1:0].
- TIMEOUT, 16, maximum cycles to wait for bus_ack on one beat; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  execute stage presents a memory operation.
- req_ready  output  1  unit can accept a request; equals (state==IDLE).
- MemRead  input  1  load (ld).
- MemWrite  input  1  store (sd).
- alu_result  input  64  effective address.
- write_data  input  64  store data (rs2).
- resp_valid  output  1  one-cycle pulse: operation finished.
- resp_err  output  1  qualifies resp_valid: misaligned, illegal op, or timeout.
- read_data  output  64  load result; holds until the next successful load.
- stall  output  1  freeze PC and pipeline.
- bus_req  output  1  bus beat request.
- bus_we  output  1  1 = write beat.
- bus_addr  output  ADDR_W  beat byte address.
- bus_wdata  output  32  write beat data.
- bus_ack  input  1  beat accepted/completed; bus_rdata is valid in the same cycle for reads.
- bus_rdata  input  32  read beat data.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; all outputs 0 except req_ready=1.
  - Internal address, data and timeout registers cleared.
  - Reset mid-transfer abandons the beat immediately; no resp_valid is produced.
- Accept condition: req_valid && req_ready && (MemRead||MemWrite).
  - req_valid with neither MemRead nor MemWrite: ignored, no response.
  - On accept, latch the address, write_data and op.
- States: IDLE, LO, HI, RESP.
- IDLE, on accept:
  - addr[2:0]!=0, or MemRead&&MemWrite → RESP with err=1. No bus activity.
  - Otherwise → LO.
- LO:
  - Drives bus_req=1, bus_addr=A, bus_we=op_write, bus_wdata=wdata[31:0].
  - On bus_ack: capture bus_rdata into the low half of the read buffer (reads only) → HI.
- HI:
  - Drives bus_req=1, bus_addr=A+4 (modulo 2^ADDR_W), bus_wdata=wdata[63:32].
  - On bus_ack: capture the high half (reads only) → RESP with err=0.
- RESP:
  - resp_valid=1 for exactly one cycle, resp_err per the outcome.
  - Successful load: read_data = {hi,lo}, updated in the same cycle resp_valid rises.
  - → IDLE.
- Bus rules:
  - bus_req, bus_addr, bus_we and bus_wdata stay stable while bus_req=1 and bus_ack=0.
  - bus_req is 0 in IDLE and RESP.
  - bus_ack with bus_req=0 is ignored.
- Timeout (TIMEOUT>0):
  - Counter clears on entry to LO and to HI; increments each cycle without ack.
  - Reaching TIMEOUT → RESP with err=1, bus_req dropped.
  - read_data is not updated on err; a write beat already acked is not rolled back.
- stall = (state!=IDLE && state!=RESP) || (accept condition in IDLE) || (state==IDLE && next-state RESP).
  - Net effect: PC holds from the accept cycle until the RESP cycle; stall is 0 during RESP.
- Latency:
  - Aligned access with ack on the first cycle of each beat: accept at T, LO at T+1, HI at T+2, resp_valid at T+3.
  - Misaligned/illegal: resp_valid at T+1.
- Endianness: little-endian; the low word is at the lower address.

Test Plan:
- Aligned load at 0x1000, bus returns 0xDEADBEEF then 0x01234567 with immediate ack → beat addrs 0x1000, 0x1004; resp_valid at T+3, resp_err=0, read_data=0x01234567DEADBEEF; stall high T..T+2.
- Store 0xAAAABBBBCCCCDDDD to 0x2008, ack delayed 3 cycles per beat → bus_wdata 0xCCCCDDDD at 0x2008, then 0xAAAABBBB at 0x200C; signals stable during the wait; resp_valid once, read_data unchanged.
- Load at 0x1004 (misaligned) → no bus_req; resp_valid=1, resp_err=1 at T+1; req_ready back to 1 at T+2.
- Load with bus_ack never asserted, TIMEOUT=16 → bus_req held 16 cycles, then dropped; resp_err=1; read_data keeps its previous value.
- rst_n pulsed low during the HI beat → bus_req=0 and req_ready=1 immediately; no resp_valid; a new load afterwards completes normally.
- MemRead=MemWrite=1 → error response, no bus activity. req_valid with both low → no response, stall=0.
